sakebi_rmii_tx: RTL

RMII transmit framer: the transmit-direction counterpart of the RMII receive path. It accepts frame payload bytes on an AXI-Stream slave in the REF_CLK domain and emits preamble, SFD, payload, zero-padding and IEEE 802.3 FCS as 2-bit dibits on the RMII TX pins at 100 Mb/s, then enforces the inter-frame gap. The block sits between the MAC-side packet source and the PHY.

---
 rtl/sakebi_rmii_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sakebi_rmii_tx.sv
// sakebi_rmii_tx: RMII transmit framer, AXI-Stream bytes in,
// preamble/SFD/payload/pad/FCS dibits out at 100 Mb/s, then IFG.
// Ports:
//   i_rmii_REF_CLK  50 MHz reference clock, clocks all logic
//   i_axis_ARESETn  async active-low reset
//   i_axis_T*       AXIS slave: TVALID/TREADY/TDATA/TLAST
//   o_rmii_TX_EN    registered transmit enable
//   o_rmii_TXD      registered dibit, bit 0 first in time
//   o_tx_busy       high whenever not idle
//   o_tx_underrun   one-cycle pulse when a required byte is missing
module sakebi_rmii_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PAD_EN     = 1,
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 48
) (
  input  logic                  i_rmii_REF_CLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_axis_TVALID,
  output logic                  o_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_axis_TDATA,
  input  logic                  i_axis_TLAST,
  output logic                  o_rmii_TX_EN,
  output logic [1:0]            o_rmii_TXD,
  output logic                  o_tx_busy,
  output logic                  o_tx_underrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAD   = 3'd3;
  localparam logic [2:0] S_FCS   = 3'd4;
  localparam logic [2:0] S_IFG   = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  localparam int CW =
    $clog2((IFG_CYCLES > 32) ? IFG_CYCLES : 32) + 1;
  localparam int BW = $clog2(MIN_FRAME + 1);

  localparam logic [BW-1:0] MINF     = BW'(MIN_FRAME);
  localparam logic [CW-1:0] PRE_LAST = CW'(31);
  localparam logic [CW-1:0] FCS_LAST = CW'(15);
  localparam logic [CW-1:0] BYTE_END = CW'(3);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);

  logic [2:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  last_q, last_n;
  logic [31:0]           crc, crc_n;
  logic [BW-1:0]         bcnt, bcnt_n, bcnt_inc;
  logic                  txen_q, txen_n;
  logic [1:0]            txd_q, txd_n;
  logic                  urun_q, urun_n;
  logic                  tready;

  // Reflected CRC-32, two bits per cycle, bit 0 first.
  function automatic logic [31:0] crc2(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign bcnt_inc = (bcnt == MINF) ? bcnt : bcnt + BW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    last_n  = last_q;
    crc_n   = crc;
    bcnt_n  = bcnt;
    txen_n  = 1'b0;
    txd_n   = 2'b00;
    urun_n  = 1'b0;
    tready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n  = '0;
        crc_n  = '1;
        bcnt_n = '0;
        if (i_axis_TVALID) state_n = S_PRE;
      end
      S_PRE: begin
        txen_n = 1'b1;
        txd_n  = (cnt == PRE_LAST) ? 2'b11 : 2'b01;
        cnt_n  = cnt + CW'(1);
        if (cnt == PRE_LAST) begin
          tready = 1'b1;
          cnt_n  = '0;
          if (i_axis_TVALID) begin
            sh_n    = i_axis_TDATA;
            last_n  = i_axis_TLAST;
            state_n = S_DATA;
          end else begin
            txen_n  = 1'b0;
            urun_n  = 1'b1;
            state_n = S_DRAIN;
          end
        end
      end
      S_DATA: begin
        txen_n = 1'b1;
        txd_n  = sh[1:0];
        sh_n   = {2'b00, sh[DATA_WIDTH-1:2]};
        crc_n  = crc2(crc, sh[1:0]);
        cnt_n  = cnt + CW'(1);
        if (cnt == BYTE_END) begin
          cnt_n  = '0;
          bcnt_n = bcnt_inc;
          if (last_q) begin
            if (PAD_EN != 0 && bcnt_inc < MINF)
              state_n = S_PAD;
            else
              state_n = S_FCS;
          end else begin
            tready = 1'b1;
            if (i_axis_TVALID) begin
              sh_n   = i_axis_TDATA;
              last_n = i_axis_TLAST;
            end else begin
              txen_n  = 1'b0;
              urun_n  = 1'b1;
              state_n = S_DRAIN;
            end
          end
        end
      end
      S_PAD: begin
        txen_n = 1'b1;
        crc_n  = crc2(crc, 2'b00);
        cnt_n  = cnt + CW'(1);
        if (cnt == BYTE_END) begin
          cnt_n  = '0;
          bcnt_n = bcnt_inc;
          if (bcnt_inc == MINF) state_n = S_FCS;
        end
      end
      S_FCS: begin
        // Register holds the running CRC; send it inverted.
        txen_n = 1'b1;
        txd_n  = ~crc[1:0];
        crc_n  = {2'b00, crc[31:2]};
        cnt_n  = cnt + CW'(1);
        if (cnt == FCS_LAST) begin
          cnt_n   = '0;
          state_n = S_IFG;
        end
      end
      S_IFG: begin
        crc_n  = '1;
        bcnt_n = '0;
        cnt_n  = cnt + CW'(1);
        if (cnt == IFG_LAST) begin
          cnt_n = '0;
          // A waiting frame starts without passing through idle.
          state_n = i_axis_TVALID ? S_PRE : S_IDLE;
        end
      end
      S_DRAIN: begin
        tready = 1'b1;
        cnt_n  = '0;
        if (i_axis_TVALID && i_axis_TLAST) state_n = S_IFG;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sh     <= '0;
      last_q <= 1'b0;
      crc    <= '1;
      bcnt   <= '0;
      txen_q <= 1'b0;
      txd_q  <= 2'b00;
      urun_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      last_q <= last_n;
      crc    <= crc_n;
      bcnt   <= bcnt_n;
      txen_q <= txen_n;
      txd_q  <= txd_n;
      urun_q <= urun_n;
    end
  end

  assign o_axis_TREADY = tready;
  assign o_rmii_TX_EN  = txen_q;
  assign o_rmii_TXD    = txd_q;
  assign o_tx_busy     = (state != S_IDLE);
  assign o_tx_underrun = urun_q;

endmodule
